// File: rtl/flow_merger.sv
// Re-serialises descrambled (flow_0, flow_1) block pairs into one block stream, buffered in a small pair FIFO.
// Optional feature: define FLOW_MERGER_DROP_CNT_EN to add the saturating o_drop_cnt dropped-pair counter.
module flow_merger #(
    parameter int BITS_BLOCK = 257,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [BITS_BLOCK-1:0]         flow_0,
    input  logic [BITS_BLOCK-1:0]         flow_1,
    input  logic                          i_ready,
    output logic [BITS_BLOCK-1:0]         data_out,
    output logic                          valid_out,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
`ifdef FLOW_MERGER_DROP_CNT_EN
    ,
    output logic [15:0]                   o_drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [2*BITS_BLOCK-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    phase_q, phase_d;
    logic [BITS_BLOCK-1:0]   dout_q, dout_d;
    logic                    vout_q, vout_d;
    logic                    ovf_q, ovf_d;
    logic                    fire_s, load_s, pop_s, push_s, drop_s;
    logic [2*BITS_BLOCK-1:0] head_s;
    logic [BITS_BLOCK-1:0]   half_s;

    // Handshake decode; a full FIFO still accepts a pair when the head is popped on the same edge.
    always_comb begin
        fire_s = !vout_q || i_ready;
        load_s = fire_s && (level_q != '0);
        pop_s  = load_s && phase_q;
        push_s = i_valid && ((level_q < DEPTH_L) || pop_s);
        drop_s = i_valid && !push_s;
        head_s = mem_q[rd_ptr_q];
        if (phase_q) begin
            half_s = head_s[2*BITS_BLOCK-1:BITS_BLOCK];
        end else begin
            half_s = head_s[BITS_BLOCK-1:0];
        end
    end

    // Pointer, occupancy and sticky overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | drop_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            level_d = level_q + LW'(1);
        end else if (!push_s && pop_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Output register: load the half chosen by phase, go idle when empty, hold under backpressure.
    always_comb begin
        dout_d  = dout_q;
        vout_d  = vout_q;
        phase_d = phase_q;
        if (fire_s) begin
            if (load_s) begin
                dout_d  = half_s;
                vout_d  = 1'b1;
                phase_d = ~phase_q;
            end else begin
                vout_d  = 1'b0;
            end
        end else begin
            dout_d  = dout_q;
            vout_d  = vout_q;
        end
    end

    // Pair storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {flow_1, flow_0};
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= 1'b0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_out   = dout_q;
    assign valid_out  = vout_q;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;

`ifdef FLOW_MERGER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Dropped-pair counter, saturating at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/flow_merger.md
# flow_merger

Receive-side inverse of the TX flow distributor. It accepts descrambled 257-bit block pairs (flow_0, flow_1) from the two per-flow descramblers and re-serialises them into a single block stream in original TX order: flow_0 first, then flow_1. It sits between the descrambler pair and the RX block consumer/checker. A small pair FIFO absorbs sink backpressure, and the block reports overflow when a pair arrives with no room.

## Interface
- BITS_BLOCK, 257, width of one transcoded block
- FIFO_DEPTH, 4, pair FIFO depth in entries (one entry = flow_0 + flow_1); power of two, ≥ 2
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  flow_0/flow_1 hold a new pair this cycle; single-cycle qualifier, no upstream backpressure
- flow_0  in  BITS_BLOCK  first block of the pair
- flow_1  in  BITS_BLOCK  second block of the pair
- i_ready  in  1  sink accepts data_out this cycle
- data_out  out  BITS_BLOCK  merged block stream
- valid_out  out  1  data_out valid
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy in pairs
- o_overflow  out  1  sticky: a pair was dropped

## Operation
- Write side:
  - i_valid=1 with level<FIFO_DEPTH: push {flow_1, flow_0}.
  - If level==FIFO_DEPTH but a pop occurs in the same cycle, the push is still accepted.
  - Otherwise the pair is dropped whole (never half-written) and o_overflow is set.
- Read side: output register plus a 1-bit phase (0 = next out is flow_0, 1 = next out is flow_1).
  - Load condition: (!valid_out || i_ready) && level>0.
  - On load: data_out ← head half selected by phase; valid_out ← 1; phase toggles.
  - Loading the flow_1 half (phase=1) pops the head entry.
  - (!valid_out || i_ready) && level==0: valid_out ← 0.
  - valid_out && !i_ready: data_out and valid_out hold bit-stable.
- Order guarantee: output is f0(0), f1(0), f0(1), f1(1), … with no gaps while data is available and i_ready=1.
- Pointers wrap modulo FIFO_DEPTH. level counts pairs, including the head entry whose flow_0 half has already been issued.
- o_overflow clears only on reset.
- Reset (asynchronous, any time): valid_out=0, data_out=0, phase=0, pointers=0, o_level=0, o_overflow=0. FIFO contents are don't-care. A pair in flight is discarded.

## Timing
- Push at edge k (i_valid sampled high, FIFO empty, output idle):
  - data_out=flow_0, valid_out=1 after edge k+1.
  - data_out=flow_1 after edge k+2 (with i_ready=1); o_level returns to 0 after edge k+2.
- Sustained throughput: 1 block/cycle out, so the average i_valid rate must be ≤ 1 per 2 cycles; the TX distributor guarantees this.
- A push and pop in the same cycle leave o_level unchanged.
- o_level and o_overflow update on the same edge as the push/drop.

## Configuration
- FLOW_MERGER_DROP_CNT_EN defined:
  - Adds output o_drop_cnt [15:0]: the count of dropped pairs.
  - Increments on the same edge that sets o_overflow and saturates at 16'hFFFF.
  - Reset value 0.
- FLOW_MERGER_DROP_CNT_EN undefined: port and counter are absent; o_overflow behaviour is identical.

## Test plan
- Single pair: flow_0=257'h1, flow_1=257'h2, i_ready=1 → data_out 1 then 2 on consecutive cycles after a 1-edge push delay; valid_out then 0; o_level 0.
- Stream: pair n = (2n, 2n+1) every 2nd cycle, n=0..99, i_ready=1 → data_out 0..199 in order, gapless, o_overflow=0.
- Stall: push 4 pairs, i_ready=0 for 10 cycles → data_out holds flow_0 of pair 0 stable; o_level=4. Release → 8 blocks in order.
- Overflow: i_ready=0, push 5 pairs → 5th dropped, o_overflow=1, o_level=4. Drain → exactly 8 blocks, pair 4 absent. With FLOW_MERGER_DROP_CNT_EN, o_drop_cnt=1.
- Full plus simultaneous pop: level=4, raise i_ready on the cycle the phase-1 half loads while i_valid=1 → push accepted, o_overflow stays 0.
- Mid-operation reset: assert rst low after flow_0 issued → valid_out=0 and o_level=0 immediately (async). After release, new pair (A, B) → output A, B with no stale flow_1.
